alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: sequences one command at a time through an external
// combinational ALU. A command is latched in IDLE, the ALU is driven for one
// EXEC cycle and its result is captured, then the result is held in RESP
// until it is consumed. An accumulator allows chaining results, sticky flags
// collect the flags of every legal result, and op_count counts legal results
// delivered.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high; a source holds valid and its payload stable
// until that edge, and ready may depend only on the module's own state.
module alu_cmd_issuer #(
  parameter int CNT_W  = 16,
  parameter int OP_MAX = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  output logic [7:0]       alu_x,
  output logic [7:0]       alu_y,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic [3:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [3:0]       res_flags,
  output logic             res_err,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MAX_L = 4'(OP_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] acc;
  logic       cmd_fire;
  logic       res_fire;
  logic       op_illegal;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign res_fire   = res_valid & res_ready;
  // alu_sel holds the latched opcode for the whole EXEC cycle.
  assign op_illegal = (alu_sel > OP_MAX_L);

  // State register; reset returns to IDLE and drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_fire) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (res_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RESP:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand/opcode registers: loaded on command accept, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_x   <= 8'h00;
      alu_y   <= 8'h00;
      alu_sel <= 4'h0;
    end else if (cmd_fire) begin
      alu_x   <= cmd_use_acc ? acc : cmd_a;
      alu_y   <= cmd_b;
      alu_sel <= cmd_op;
    end
  end

  // Result capture at the end of EXEC; illegal opcodes yield a fixed error result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data  <= 8'h00;
      res_flags <= 4'h0;
      res_err   <= 1'b0;
    end else if (state == S_EXEC) begin
      if (op_illegal) begin
        res_data  <= 8'h00;
        res_flags <= 4'b0001;
        res_err   <= 1'b1;
      end else begin
        res_data  <= alu_out;
        res_flags <= alu_flags;
        res_err   <= 1'b0;
      end
    end
  end

  // Sticky flags: accumulate legal captures; a clear in the capture cycle
  // drops only the old bits, a clear in any other cycle zeroes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= 4'h0;
    end else if ((state == S_EXEC) && !op_illegal) begin
      sticky_flags <= (sticky_clr ? 4'h0 : sticky_flags) | alu_flags;
    end else if (sticky_clr) begin
      sticky_flags <= 4'h0;
    end
  end

  // Accumulator and saturating result counter, updated when a legal result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= 8'h00;
      op_count <= '0;
    end else if (res_fire && !res_err) begin
      acc <= res_data;
      if (op_count != {CNT_W{1'b1}}) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer with a small external ALU model.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        cmd_use_acc;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flags;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [3:0]  res_flags;
  logic        res_err;
  logic [3:0]  sticky_flags;
  logic        sticky_clr;
  logic [15:0] op_count;

  int vectors = 0;
  int fails   = 0;
  logic [7:0] exp_q[$];

  alu_cmd_issuer #(.CNT_W(16), .OP_MAX(14)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_err(res_err),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .op_count(op_count)
  );

  // Clock
  always #5 clk = ~clk;

  // External ALU model: flags are {negative, overflow, carry, zero}.
  always_comb begin
    logic [8:0] wide;
    logic       c;
    logic       v;
    wide = 9'h000;
    c    = 1'b0;
    v    = 1'b0;
    case (alu_sel)
      4'd0: begin
        wide = {1'b0, alu_x} + {1'b0, alu_y};
        c    = wide[8];
        v    = (alu_x[7] == alu_y[7]) && (wide[7] != alu_x[7]);
      end
      4'd1: begin
        wide = {1'b0, alu_x} - {1'b0, alu_y};
        c    = (alu_x < alu_y);
        v    = (alu_x[7] != alu_y[7]) && (wide[7] != alu_x[7]);
      end
      4'd3: wide = {1'b0, alu_x & alu_y};
      4'd5: wide = {1'b0, alu_x ^ alu_y};
      default: wide = 9'h000;
    endcase
    alu_out   = wide[7:0];
    alu_flags = {wide[7], v, c, (wide[7:0] == 8'h00)};
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command in IDLE for one cycle; the expected result joins the queue.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input logic [7:0] exp_data);
    check("ready_before_issue", 16'(cmd_ready), 16'h1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    exp_q.push_back(exp_data);
    step();
    cmd_valid = 1'b0;
    cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_use_acc = 1'b0;
    check("exec_cmd_ready", 16'(cmd_ready), 16'h0);
    check("exec_res_valid", 16'(res_valid), 16'h0);
  endtask

  // Advance through EXEC and compare the captured result.
  task automatic expect_result(input logic [3:0] exp_flags, input logic exp_err);
    logic [7:0] exp_data;
    step();
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("res_valid", 16'(res_valid), 16'h1);
    check("res_data", 16'(res_data), 16'(exp_data));
    check("res_flags", 16'(res_flags), 16'(exp_flags));
    check("res_err", 16'(res_err), 16'(exp_err));
  endtask

  // Consume the result (res_ready held high) and check return to IDLE.
  task automatic consume(input logic [15:0] exp_count);
    res_ready = 1'b1;
    step();
    check("idle_res_valid", 16'(res_valid), 16'h0);
    check("idle_cmd_ready", 16'(cmd_ready), 16'h1);
    check("op_count", op_count, exp_count);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_use_acc = 1'b0; res_ready = 1'b0; sticky_clr = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset values
    check("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    check("rst_res_valid", 16'(res_valid), 16'h0);
    check("rst_res_data", 16'(res_data), 16'h0);
    check("rst_res_flags", 16'(res_flags), 16'h0);
    check("rst_res_err", 16'(res_err), 16'h0);
    check("rst_alu_x", 16'(alu_x), 16'h0);
    check("rst_alu_y", 16'(alu_y), 16'h0);
    check("rst_alu_sel", 16'(alu_sel), 16'h0);
    check("rst_sticky", 16'(sticky_flags), 16'h0);
    check("rst_op_count", op_count, 16'h0);

    // Add 0x7F + 0x01 -> 0x80, overflow
    res_ready = 1'b1;
    issue(4'd0, 8'h7F, 8'h01, 1'b0, 8'h80);
    check("add_alu_x", 16'(alu_x), 16'h7F);
    check("add_alu_y", 16'(alu_y), 16'h01);
    check("add_alu_sel", 16'(alu_sel), 16'h0);
    expect_result(4'b1100, 1'b0);
    check("add_sticky", 16'(sticky_flags), 16'hC);
    consume(16'd1);

    // Idle cycle with res_ready high and no result: nothing changes
    step();
    check("idle_rdy_no_effect", op_count, 16'd1);
    check("idle_alu_hold", 16'(alu_x), 16'h7F);

    // Clear sticky in an idle cycle, then Sub and accumulator-chained Add
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("sticky_clr_idle", 16'(sticky_flags), 16'h0);
    issue(4'd1, 8'h00, 8'h01, 1'b0, 8'hFF);
    expect_result(4'b1010, 1'b0);
    consume(16'd2);
    issue(4'd0, 8'h55, 8'h01, 1'b1, 8'h00);
    check("acc_alu_x", 16'(alu_x), 16'hFF);
    expect_result(4'b0011, 1'b0);
    check("chain_sticky", 16'(sticky_flags), 16'hB);
    consume(16'd3);

    // Back-pressure: result held for 5 cycles, command pulse ignored
    res_ready = 1'b0;
    issue(4'd3, 8'hF0, 8'h3C, 1'b0, 8'h30);
    expect_result(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 8'h01; cmd_b = 8'h01;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      check("bp_res_valid", 16'(res_valid), 16'h1);
      check("bp_res_data", 16'(res_data), 16'h30);
      check("bp_cmd_ready", 16'(cmd_ready), 16'h0);
    end
    cmd_valid = 1'b0;
    check("bp_alu_x_hold", 16'(alu_x), 16'hF0);
    consume(16'd4);

    // Illegal opcode: error result, no acc/count/sticky update
    issue(4'd15, 8'h12, 8'h34, 1'b0, 8'h00);
    expect_result(4'b0001, 1'b1);
    check("ill_sticky", 16'(sticky_flags), 16'hB);
    consume(16'd4);
    issue(4'd5, 8'hAA, 8'h00, 1'b1, 8'h30);
    check("ill_acc_kept", 16'(alu_x), 16'h30);
    expect_result(4'b0000, 1'b0);
    consume(16'd5);

    // Sticky clear during EXEC keeps the new bits
    issue(4'd0, 8'hFF, 8'h01, 1'b0, 8'h00);
    sticky_clr = 1'b1;
    expect_result(4'b0011, 1'b0);
    sticky_clr = 1'b0;
    check("exec_clr_sticky", 16'(sticky_flags), 16'h3);
    consume(16'd6);

    // Reset during RESP discards the result
    res_ready = 1'b0;
    issue(4'd0, 8'h01, 8'h01, 1'b0, 8'h02);
    expect_result(4'b0000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_res_valid", 16'(res_valid), 16'h0);
    check("rr_cmd_ready", 16'(cmd_ready), 16'h1);
    check("rr_op_count", op_count, 16'h0);
    check("rr_res_data", 16'(res_data), 16'h0);
    check("rr_sticky", 16'(sticky_flags), 16'h0);
    check("rr_alu_x", 16'(alu_x), 16'h0);
    issue(4'd0, 8'h77, 8'h05, 1'b1, 8'h05);
    check("rr_acc_zero", 16'(alu_x), 16'h0);
    expect_result(4'b0000, 1'b0);
    consume(16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
